// File: rtl/fetch_unit.sv
// fetch_unit: program counter and single-outstanding instruction fetch stage
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc_in,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr_out,
   output logic        instr_valid
);
   typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
   state_t      state;
   logic        drop;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        valid;
   assign pc_out      = pc;
   assign pc_plus4    = pc + 32'd4;
   assign imem_addr   = pc;
   assign imem_req    = (state == REQ) && !drop;
   assign instr_out   = instr;
   assign instr_valid = valid;
   // fetch sequencing; drop tracks a response still owed to a flushed request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         drop  <= 1'b0;
         pc    <= RESET_PC;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (flush) begin
         pc    <= flush_pc & ~32'd3;
         valid <= 1'b0;
         instr <= NOP_INSTR;
         state <= REQ;
         drop  <= (drop && !imem_rvalid) || (state == WAIT && !imem_rvalid) || (imem_req && imem_gnt);
      end else begin
         case (state)
            BOOT: state <= REQ;
            REQ: begin
               if (drop) begin
                  if (imem_rvalid) drop <= 1'b0;
               end else if (imem_gnt) state <= WAIT;
            end
            WAIT: begin
               if (imem_rvalid) begin
                  instr <= imem_rdata;
                  valid <= 1'b1;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pc    <= next_pc_in & ~32'd3;
                  valid <= 1'b0;
                  instr <= NOP_INSTR;
                  state <= REQ;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end
endmodule
